// File: rtl/grid_click_picker.sv
// Mouse click to grid cell selector: synchronise, debounce, bounds check,
// then serial divide into a (col,row,button) selection behind valid/ready.
module grid_click_picker #(
    parameter int GRID_X0      = 40,
    parameter int GRID_Y0      = 40,
    parameter int CELL_W       = 40,
    parameter int CELL_H       = 40,
    parameter int GRID_COLS    = 10,
    parameter int GRID_ROWS    = 10,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] mouse_pos_x,
    input  logic [9:0] mouse_pos_y,
    input  logic [1:0] mouse_click,
    input  logic       sel_ready,
    output logic       sel_valid,
    output logic [3:0] sel_col,
    output logic [3:0] sel_row,
    output logic [1:0] sel_button
);

    localparam int N  = (GRID_COLS > GRID_ROWS) ? GRID_COLS : GRID_ROWS;
    localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [10:0]   X_LO     = 11'(GRID_X0);
    localparam logic [10:0]   X_HI     = 11'(GRID_X0 + GRID_COLS * CELL_W);
    localparam logic [10:0]   Y_LO     = 11'(GRID_Y0);
    localparam logic [10:0]   Y_HI     = 11'(GRID_Y0 + GRID_ROWS * CELL_H);
    localparam logic [9:0]    STEP_X   = 10'(CELL_W);
    localparam logic [9:0]    STEP_Y   = 10'(CELL_H);
    localparam logic [9:0]    OFF_X    = 10'(GRID_X0);
    localparam logic [9:0]    OFF_Y    = 10'(GRID_Y0);
    localparam logic [3:0]    DIV_LAST = 4'(N - 1);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, HOLD} state_t;

    state_t     state;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] rise;
    logic [9:0] lat_x;
    logic [9:0] lat_y;
    logic [1:0] btn;
    logic [9:0] remx;
    logic [9:0] remy;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] div_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= mouse_click;
            sync2 <= sync1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          db;
        logic          pulse;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                cnt   <= '0;
                db    <= 1'b0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (sync2[b] == db) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt   <= '0;
                    db    <= sync2[b];
                    pulse <= sync2[b];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign rise[b] = pulse;
    end

    logic       in_grid;
    logic       x_ge;
    logic       y_ge;
    logic [9:0] remx_n;
    logic [9:0] remy_n;
    logic [3:0] col_n;
    logic [3:0] row_n;

    always_comb begin
        in_grid = ({1'b0, lat_x} >= X_LO) && ({1'b0, lat_x} < X_HI) &&
                  ({1'b0, lat_y} >= Y_LO) && ({1'b0, lat_y} < Y_HI);
        x_ge   = remx >= STEP_X;
        y_ge   = remy >= STEP_Y;
        remx_n = x_ge ? remx - STEP_X : remx;
        remy_n = y_ge ? remy - STEP_Y : remy;
        col_n  = col + {3'b000, x_ge};
        row_n  = row + {3'b000, y_ge};
    end

    // Fixed-length restoring divide keeps the click-to-valid latency constant.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            sel_valid  <= 1'b0;
            sel_col    <= 4'd0;
            sel_row    <= 4'd0;
            sel_button <= 2'b00;
            lat_x      <= 10'd0;
            lat_y      <= 10'd0;
            btn        <= 2'b00;
            remx       <= 10'd0;
            remy       <= 10'd0;
            col        <= 4'd0;
            row        <= 4'd0;
            div_cnt    <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|rise) begin
                        lat_x <= mouse_pos_x;
                        lat_y <= mouse_pos_y;
                        btn   <= rise[0] ? 2'b01 : 2'b10;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (in_grid) begin
                        remx    <= lat_x - OFF_X;
                        remy    <= lat_y - OFF_Y;
                        col     <= 4'd0;
                        row     <= 4'd0;
                        div_cnt <= 4'd0;
                        state   <= DIV;
                    end else begin
                        state <= IDLE;
                    end
                end
                DIV: begin
                    remx    <= remx_n;
                    remy    <= remy_n;
                    col     <= col_n;
                    row     <= row_n;
                    div_cnt <= div_cnt + 4'd1;
                    if (div_cnt == DIV_LAST) begin
                        sel_col    <= col_n;
                        sel_row    <= row_n;
                        sel_button <= btn;
                        sel_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (sel_ready) begin
                        sel_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_click_picker.sv
// Directed bench for grid_click_picker with a scoreboard of expected
// selections popped on every valid/ready transfer.
module tb_grid_click_picker;

    localparam int DEB = 4;
    localparam int N   = 10;
    // click driven before edge E0: synced at E1, debounced rise at E(1+DEB),
    // valid N+2 edges later; k counts edges starting at 1 for E0
    localparam int LAT = DEB + N + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] mouse_pos_x = 10'd0;
    logic [9:0] mouse_pos_y = 10'd0;
    logic [1:0] mouse_click = 2'b00;
    logic       sel_ready = 1'b1;
    logic       sel_valid;
    logic [3:0] sel_col;
    logic [3:0] sel_row;
    logic [1:0] sel_button;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] sb[$];
    logic [9:0] mon_exp;

    always #5 clk = ~clk;

    grid_click_picker #(.DEBOUNCE_CYC(DEB)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .mouse_pos_x(mouse_pos_x),
        .mouse_pos_y(mouse_pos_y),
        .mouse_click(mouse_click),
        .sel_ready  (sel_ready),
        .sel_valid  (sel_valid),
        .sel_col    (sel_col),
        .sel_row    (sel_row),
        .sel_button (sel_button)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pack(input int c, input int r, input logic [1:0] b);
        return {4'(c), 4'(r), b};
    endfunction

    always @(negedge clk) begin
        if (!rst && sel_valid && sel_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_sel", int'(sel_valid), 0);
            end else begin
                mon_exp = sb.pop_front();
                chk("sel", int'({sel_col, sel_row, sel_button}), int'(mon_exp));
            end
        end
    end

    task automatic click(input logic [1:0] b, input int x, input int y,
                         input int hold, output int first, output int pulses);
        @(negedge clk);
        mouse_pos_x = 10'(x);
        mouse_pos_y = 10'(y);
        mouse_click = b;
        first  = 0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == hold) mouse_click = 2'b00;
            if (k == 9) begin
                mouse_pos_x = 10'd0;
                mouse_pos_y = 10'd0;
            end
            if (sel_valid) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        mouse_click = 2'b00;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic good(input logic [1:0] b, input int x, input int y,
                        input int c, input int r, input logic [1:0] eb, input string tag);
        int f, p;
        sb.push_back(pack(c, r, eb));
        click(b, x, y, 0, f, p);
        chk({tag, "_latency"}, f, LAT);
        chk({tag, "_pulses"}, p, 1);
    endtask

    task automatic none(input logic [1:0] b, input int x, input int y,
                        input int hold, input string tag);
        int f, p;
        click(b, x, y, hold, f, p);
        chk({tag, "_pulses"}, p, 0);
    endtask

    initial begin
        int f, p, cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(sel_valid), 0);
        chk("rst_col", int'(sel_col), 0);
        chk("rst_row", int'(sel_row), 0);
        chk("rst_button", int'(sel_button), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        good(2'b01, 45, 45, 0, 0, 2'b01, "c45");
        good(2'b01, 439, 439, 9, 9, 2'b01, "c439");
        good(2'b10, 80, 119, 1, 1, 2'b10, "right");
        good(2'b01, 79, 80, 0, 1, 2'b01, "edge");
        good(2'b01, 40, 439, 0, 9, 2'b01, "corner");

        none(2'b01, 440, 100, 0, "out_x");
        none(2'b01, 39, 60, 0, "out_lo");
        none(2'b01, 100, 100, 3, "glitch");
        good(2'b11, 120, 160, 2, 3, 2'b01, "both");

        sel_ready = 1'b0;
        sb.push_back(pack(4, 4, 2'b01));
        click(2'b01, 200, 200, 0, f, p);
        chk("hold_latency", f, LAT);
        chk("hold_pulses", p, 40 - LAT + 1);
        chk("hold_col", int'(sel_col), 4);
        chk("hold_row", int'(sel_row), 4);
        click(2'b01, 80, 119, 0, f, p);
        chk("drop_valid", p, 40);
        chk("drop_col", int'(sel_col), 4);
        chk("drop_row", int'(sel_row), 4);
        sel_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("after_xfer", int'(sel_valid), 0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (sel_valid) cnt++;
        end
        chk("no_queued", cnt, 0);

        @(negedge clk);
        mouse_pos_x = 10'd45;
        mouse_pos_y = 10'd45;
        mouse_click = 2'b01;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(sel_valid), 0);
        chk("mid_rst_col", int'(sel_col), 0);
        chk("mid_rst_row", int'(sel_row), 0);
        chk("mid_rst_button", int'(sel_button), 0);
        mouse_click = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (sel_valid) cnt++;
        end
        chk("mid_rst_none", cnt, 0);
        good(2'b01, 439, 439, 9, 9, 2'b01, "post_rst");

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
